// File: rtl/phase_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phase_detector_pkg
// Description : Shared constants for the PLL phase detector and margin
//               statistics: zone encodings, error width, degree scale.
// Revision    : 1.0 - initial release
// ============================================================================
package phase_detector_pkg;

  localparam int PHASE_ERR_W = 16;

  // Margin-zone encodings
  localparam logic [1:0] ZONE_EARLY   = 2'b00;
  localparam logic [1:0] ZONE_ON_TIME = 2'b01;
  localparam logic [1:0] ZONE_LATE    = 2'b10;
  localparam logic [1:0] ZONE_WAY_OFF = 2'b11;

  // Degree scale: full 16-bit range = 360 degrees
  localparam logic [PHASE_ERR_W-1:0] DEG_22_5 = 16'h1000;
  localparam logic [PHASE_ERR_W-1:0] DEG_45   = 16'h2000;

  // Absolute value widened by one bit so that -180 degrees (0x8000)
  // maps to +0x8000 instead of overflowing back to itself.
  function automatic logic [PHASE_ERR_W:0] phase_abs(
    input logic signed [PHASE_ERR_W-1:0] e
  );
    logic signed [PHASE_ERR_W:0] ext;
    ext = {e[PHASE_ERR_W-1], e};
    phase_abs = e[PHASE_ERR_W-1] ? $unsigned(-ext) : $unsigned(ext);
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_zone_classifier.sv
`default_nettype none
// ============================================================================
// Module      : phase_zone_classifier
// Description : Combinational margin-zone classification of a signed phase
//               error (early / on-time / late / way-off).
// Revision    : 1.0 - initial release
// ============================================================================
module phase_zone_classifier
  import phase_detector_pkg::*;
#(
  parameter logic [PHASE_ERR_W-1:0] ON_TIME_THRESH = DEG_22_5,
  parameter logic [PHASE_ERR_W-1:0] WAY_OFF_THRESH = DEG_45
) (
  input  logic signed [PHASE_ERR_W-1:0] phase_err,
  output logic        [1:0]             zone
);

  logic [PHASE_ERR_W:0] mag;

  assign mag = phase_abs(phase_err);

  // Priority: way-off, then on-time, then sign decides early vs late
  always_comb begin
    zone = ZONE_LATE;
    if (mag >= {1'b0, WAY_OFF_THRESH}) begin
      zone = ZONE_WAY_OFF;
    end else if (mag < {1'b0, ON_TIME_THRESH}) begin
      zone = ZONE_ON_TIME;
    end else if (phase_err > 0) begin
      zone = ZONE_EARLY;
    end
  end

endmodule
`default_nettype wire

// File: rtl/phase_detector.sv
`default_nettype none
// ============================================================================
// Module      : phase_detector
// Description : Samples the NCO phase on each flux-edge strobe, produces a
//               signed 16-bit phase error and a margin zone, one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_detector
  import phase_detector_pkg::*;
#(
  parameter logic [PHASE_ERR_W-1:0] ON_TIME_THRESH = DEG_22_5,
  parameter logic [PHASE_ERR_W-1:0] WAY_OFF_THRESH = DEG_45
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   edge_detected,
  input  logic [31:0]            nco_phase,
  output logic [PHASE_ERR_W-1:0] phase_error,
  output logic                   error_valid,
  output logic [1:0]             margin_zone
);

  logic signed [PHASE_ERR_W-1:0] err_now;
  logic        [1:0]             zone_now;
  logic                          unused_low_bits;

  // Phase 0 is the bit-cell centre, so the upper half read as signed is
  // already the wrapped error; the low half is dropped by truncation.
  assign err_now         = $signed(nco_phase[31:16]);
  assign unused_low_bits = ^nco_phase[15:0];

  phase_zone_classifier #(
    .ON_TIME_THRESH (ON_TIME_THRESH),
    .WAY_OFF_THRESH (WAY_OFF_THRESH)
  ) u_zone (
    .phase_err (err_now),
    .zone      (zone_now)
  );

  // Capture error and zone on each strobe; hold otherwise; valid is sticky
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_error <= '0;
      error_valid <= 1'b0;
      margin_zone <= ZONE_ON_TIME;
    end else if (edge_detected) begin
      phase_error <= err_now;
      error_valid <= 1'b1;
      margin_zone <= zone_now;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phase_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_detector
// Description : Directed self-checking bench for phase_detector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_detector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        edge_detected = 1'b0;
  logic [31:0] nco_phase = '0;
  logic [15:0] phase_error;
  logic        error_valid;
  logic [1:0]  margin_zone;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  phase_detector dut (
    .clk           (clk),
    .reset         (reset),
    .edge_detected (edge_detected),
    .nco_phase     (nco_phase),
    .phase_error   (phase_error),
    .error_valid   (error_valid),
    .margin_zone   (margin_zone)
  );

  task automatic check(input string tag, input logic [15:0] pe,
                       input logic [1:0] zn, input logic vld);
    n_cmp++;
    assert (phase_error === pe) else begin
      n_err++;
      $error("FAIL %s phase_error: got %h expected %h", tag, phase_error, pe);
    end
    n_cmp++;
    assert (margin_zone === zn) else begin
      n_err++;
      $error("FAIL %s margin_zone: got %b expected %b", tag, margin_zone, zn);
    end
    n_cmp++;
    assert (error_valid === vld) else begin
      n_err++;
      $error("FAIL %s error_valid: got %b expected %b", tag, error_valid, vld);
    end
  endtask

  // One-cycle strobe, then garbage on nco_phase while strobe is low
  task automatic strobe(input logic [31:0] p);
    @(negedge clk);
    edge_detected = 1'b1;
    nco_phase     = p;
    @(negedge clk);
    edge_detected = 1'b0;
    nco_phase     = $urandom;
  endtask

  initial begin
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("in_reset", 16'h0000, 2'b01, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_reset", 16'h0000, 2'b01, 1'b0);

    strobe(32'h0000_0000);
    check("zero", 16'h0000, 2'b01, 1'b1);
    repeat (3) @(negedge clk);
    check("zero_held", 16'h0000, 2'b01, 1'b1);

    nco_phase = 32'h4000_0000;
    repeat (2) @(negedge clk);
    check("ignored_no_strobe", 16'h0000, 2'b01, 1'b1);

    strobe(32'h1000_0000); check("early_22_5", 16'h1000, 2'b00, 1'b1);
    strobe(32'hF000_0000); check("late_22_5",  16'hF000, 2'b10, 1'b1);
    strobe(32'h4000_0000); check("plus_90",    16'h4000, 2'b11, 1'b1);
    strobe(32'hC000_0000); check("minus_90",   16'hC000, 2'b11, 1'b1);
    strobe(32'h8000_0000); check("at_180",     16'h8000, 2'b11, 1'b1);
    strobe(32'h2000_0000); check("plus_45",    16'h2000, 2'b11, 1'b1);
    strobe(32'h1FFF_FFFF); check("below_45",   16'h1FFF, 2'b00, 1'b1);
    strobe(32'hE000_0000); check("minus_45",   16'hE000, 2'b11, 1'b1);
    strobe(32'h0FFF_FFFF); check("below_22_5", 16'h0FFF, 2'b01, 1'b1);
    strobe(32'hE000_0001); check("minus_45_trunc", 16'hE000, 2'b11, 1'b1);
    strobe(32'hF800_0000); check("late_small", 16'hF800, 2'b01, 1'b1);
    strobe(32'hEFFF_0000); check("late_mid",   16'hEFFF, 2'b10, 1'b1);

    // Back-to-back strobes: each one lands the cycle after it is driven
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      edge_detected = 1'b1;
      nco_phase     = 32'(i) << 28;
      @(posedge clk);
      #1;
      check($sformatf("b2b_%0d", i), 16'(i) << 12,
            (i == 0) ? 2'b01 : ((i == 1) ? 2'b00 : 2'b11), 1'b1);
    end
    @(negedge clk);
    edge_detected = 1'b0;
    nco_phase     = 32'h0;
    check("b2b_final", 16'h7000, 2'b11, 1'b1);

    strobe(32'h5000_0000);
    check("pre_reset", 16'h5000, 2'b11, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("one_cycle_reset", 16'h0000, 2'b01, 1'b0);

    strobe(32'h3000_0000);
    check("post_reset_strobe", 16'h3000, 2'b11, 1'b1);
    @(negedge clk);
    reset         = 1'b1;
    edge_detected = 1'b1;
    nco_phase     = 32'h1000_0000;
    @(negedge clk);
    reset         = 1'b0;
    edge_detected = 1'b0;
    check("reset_vs_strobe", 16'h0000, 2'b01, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
